// File: rtl/msp_trace_buf_pkg.sv
// ============================================================================
// Module   : msp_trace_buf_pkg
// Brief    : Shared trace-buffer encodings: FSM states, entry layout, widths.
//            Entry width depends on the MSP_TRACE_CYCLE_EN macro.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package msp_trace_buf_pkg;

   localparam logic [1:0] c_ST_IDLE    = 2'd0;
   localparam logic [1:0] c_ST_ARMED   = 2'd1;
   localparam logic [1:0] c_ST_CAPTURE = 2'd2;
   localparam logic [1:0] c_ST_DONE    = 2'd3;

   // Entry layout: {cycle stamp (optional), irq, code[15:0], pc[15:0]}
   localparam int c_PC_LSB      = 0;
   localparam int c_CODE_LSB    = 16;
   localparam int c_IRQ_BIT     = 32;
   localparam int c_CYC_LSB     = 33;
   localparam int c_ENTRY_W_BASE = 33;
   localparam int c_ENTRY_W_CYC  = 49;

`ifdef MSP_TRACE_CYCLE_EN
   localparam int c_ENTRY_W = c_ENTRY_W_CYC;
`else
   localparam int c_ENTRY_W = c_ENTRY_W_BASE;
`endif

endpackage

`default_nettype wire

// File: rtl/msp_trace_ram.sv
// ============================================================================
// Module   : msp_trace_ram
// Brief    : DEPTH x WIDTH register array, one write port, one async read port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module msp_trace_ram #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 33
) (
   input  logic                     mclk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [WIDTH-1:0]         wdata,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [WIDTH-1:0]         rdata
);

   logic [WIDTH-1:0] r_mem [DEPTH];

   // Storage is deliberately not reset; validity is tracked by the count.
   always_ff @(posedge mclk) begin
      if (we) begin
         r_mem[waddr] <= wdata;
      end
   end

   assign rdata = r_mem[raddr];

endmodule

`default_nettype wire

// File: rtl/msp_trace_buf.sv
// ============================================================================
// Module   : msp_trace_buf
// Brief    : Instruction/IRQ trace buffer with PC trigger and show-ahead read.
//            Define MSP_TRACE_CYCLE_EN to add a 16-bit inter-entry cycle stamp.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module msp_trace_buf
   import msp_trace_buf_pkg::*;
#(
   parameter int          DEPTH   = 16,
   parameter logic [15:0] TRIG_PC = 16'hFFFF
) (
   input  logic                       mclk,
   input  logic                       puc_n,
   input  logic                       decode,
   input  logic [15:0]                pc,
   input  logic [15:0]                ir,
   input  logic                       irq_detect,
   input  logic [3:0]                 irq_num,
   input  logic                       arm,
   input  logic                       stop,
   input  logic [15:0]                trig_pc,
   output logic                       rd_valid,
   input  logic                       rd_ready,
   output logic [c_ENTRY_W-1:0]       rd_data,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       overflow,
   output logic [1:0]                 state
);

   localparam int AW    = $clog2(DEPTH);
   localparam int CNT_W = AW + 1;
   localparam logic [CNT_W-1:0] c_FULL    = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);
   localparam logic [AW-1:0]    c_PTR_ONE = AW'(1);

   logic [1:0]           r_state;
   logic [1:0]           w_state_nxt;
   logic [AW-1:0]        r_wr_ptr;
   logic [AW-1:0]        r_rd_ptr;
   logic [CNT_W-1:0]     r_count;
   logic                 r_overflow;
   logic [15:0]          r_trig;
   logic                 w_hit;
   logic                 w_full;
   logic                 w_push_req;
   logic                 w_push;
   logic                 w_pop;
   logic                 w_drop;
   logic [c_ENTRY_W-1:0] w_entry;

   assign w_hit  = decode && (pc == r_trig);
   assign w_full = (r_count == c_FULL);

   // State register
   always_ff @(posedge mclk) begin
      if (!puc_n) begin
         r_state <= c_ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic; arm overrides everything else
   always_comb begin
      w_state_nxt = r_state;
      if (arm) begin
         w_state_nxt = c_ST_ARMED;
      end else begin
         case (r_state)
            c_ST_IDLE:    w_state_nxt = c_ST_IDLE;
            c_ST_ARMED: begin
               if (stop)       w_state_nxt = c_ST_DONE;
               else if (w_hit) w_state_nxt = c_ST_CAPTURE;
            end
            c_ST_CAPTURE: begin
               if (stop || w_full) w_state_nxt = c_ST_DONE;
            end
            c_ST_DONE:    w_state_nxt = c_ST_DONE;
            default:      w_state_nxt = c_ST_IDLE;
         endcase
      end
   end

   // Output logic: push/pop/drop qualification
   always_comb begin
      w_push_req = 1'b0;
      case (r_state)
         c_ST_ARMED:   w_push_req = w_hit;
         c_ST_CAPTURE: w_push_req = decode;
         default:      w_push_req = 1'b0;
      endcase
      w_push_req = w_push_req && !arm;
      w_pop      = rd_valid && rd_ready && !arm;
      w_push     = w_push_req && (!w_full || w_pop);
      w_drop     = w_push_req && w_full && !w_pop;
   end

   always_ff @(posedge mclk) begin
      if (!puc_n) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
         r_trig     <= TRIG_PC;
      end else if (arm) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
         r_trig     <= trig_pc;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + c_CNT_ONE;
            2'b01:   r_count <= r_count - c_CNT_ONE;
            default: r_count <= r_count;
         endcase
         if (w_drop) r_overflow <= 1'b1;
      end
   end

`ifdef MSP_TRACE_CYCLE_EN
   logic [15:0] r_cyc;
   logic [15:0] w_cyc_inc;

   assign w_cyc_inc = (r_cyc == 16'hFFFF) ? r_cyc : r_cyc + 16'd1;

   // Counts edges since the last recorded entry; stored value includes this edge
   always_ff @(posedge mclk) begin
      if (!puc_n) begin
         r_cyc <= '0;
      end else if (arm || w_push) begin
         r_cyc <= '0;
      end else begin
         r_cyc <= w_cyc_inc;
      end
   end
`endif

   always_comb begin
      w_entry = '0;
      w_entry[c_PC_LSB +: 16]   = pc;
      w_entry[c_CODE_LSB +: 16] = irq_detect ? {12'h000, irq_num} : ir;
      w_entry[c_IRQ_BIT]        = irq_detect;
`ifdef MSP_TRACE_CYCLE_EN
      w_entry[c_CYC_LSB +: 16]  = (r_state == c_ST_ARMED) ? 16'h0000 : w_cyc_inc;
`endif
   end

   msp_trace_ram #(
      .DEPTH (DEPTH),
      .WIDTH (c_ENTRY_W)
   ) u_ram (
      .mclk  (mclk),
      .we    (w_push),
      .waddr (r_wr_ptr),
      .wdata (w_entry),
      .raddr (r_rd_ptr),
      .rdata (rd_data)
   );

   assign rd_valid = (r_count != '0);
   assign count    = r_count;
   assign overflow = r_overflow;
   assign state    = r_state;

endmodule

`default_nettype wire

// File: tb/tb_msp_trace_buf.sv
// ============================================================================
// Module   : tb_msp_trace_buf
// Brief    : Directed self-checking bench for msp_trace_buf (DEPTH=16).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_msp_trace_buf;
   import msp_trace_buf_pkg::*;

   logic                  mclk = 1'b0;
   logic                  puc_n = 1'b0;
   logic                  decode = 1'b0;
   logic [15:0]           pc = '0;
   logic [15:0]           ir = '0;
   logic                  irq_detect = 1'b0;
   logic [3:0]            irq_num = '0;
   logic                  arm = 1'b0;
   logic                  stop = 1'b0;
   logic [15:0]           trig_pc = '0;
   logic                  rd_valid;
   logic                  rd_ready = 1'b0;
   logic [c_ENTRY_W-1:0]  rd_data;
   logic [4:0]            count;
   logic                  overflow;
   logic [1:0]            state;

   int checks = 0;
   int errors = 0;

   msp_trace_buf #(.DEPTH(16), .TRIG_PC(16'hFFFF)) dut (
      .mclk       (mclk),
      .puc_n      (puc_n),
      .decode     (decode),
      .pc         (pc),
      .ir         (ir),
      .irq_detect (irq_detect),
      .irq_num    (irq_num),
      .arm        (arm),
      .stop       (stop),
      .trig_pc    (trig_pc),
      .rd_valid   (rd_valid),
      .rd_ready   (rd_ready),
      .rd_data    (rd_data),
      .count      (count),
      .overflow   (overflow),
      .state      (state)
   );

   always #5 mclk = ~mclk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge mclk);
      #1;
   endtask

   task automatic do_arm(input logic [15:0] t);
      arm = 1'b1; trig_pc = t;
      tick();
      arm = 1'b0;
   endtask

   task automatic dec(input logic [15:0] p, input logic [15:0] i);
      decode = 1'b1; pc = p; ir = i;
      tick();
      decode = 1'b0;
   endtask

   task automatic pop();
      rd_ready = 1'b1;
      tick();
      rd_ready = 1'b0;
   endtask

   initial begin
      tick(); tick();
      chk("rst_state", 64'(state), 64'(c_ST_IDLE));
      chk("rst_count", 64'(count), 64'd0);
      chk("rst_valid", 64'(rd_valid), 64'd0);
      chk("rst_ovf", 64'(overflow), 64'd0);
      puc_n = 1'b1;
      tick();

      // Trigger and basic capture
      do_arm(16'hF000);
      chk("armed", 64'(state), 64'd1);
      dec(16'hE000, 16'h1111);
      chk("no_trig_state", 64'(state), 64'd1);
      chk("no_trig_count", 64'(count), 64'd0);
      dec(16'hF000, 16'h4001);
      dec(16'hF002, 16'h4002);
      dec(16'hF004, 16'h4003);
      chk("cap_count", 64'(count), 64'd3);
      chk("cap_state", 64'(state), 64'd2);
      chk("entry0", 64'(rd_data[32:0]), 64'h0_4001_F000);

      // IRQ entry
      irq_detect = 1'b1; irq_num = 4'hE;
      dec(16'hF006, 16'h1234);
      irq_detect = 1'b0; irq_num = 4'h0;
      chk("irq_count", 64'(count), 64'd4);
      pop();
      chk("entry1", 64'(rd_data[32:0]), 64'h0_4002_F002);
      pop();
      chk("entry2", 64'(rd_data[32:0]), 64'h0_4003_F004);
      pop();
      chk("entry_irq", 64'(rd_data[32:0]), 64'h1_000E_F006);
      pop();
      chk("drained_valid", 64'(rd_valid), 64'd0);

      // Fill to DEPTH, then DONE; extra decodes ignored
      do_arm(16'h1000);
      for (int i = 0; i < 20; i++) begin
         dec(16'h1000 + 16'(2 * i), 16'(i));
         tick();
      end
      chk("full_count", 64'(count), 64'd16);
      chk("full_state", 64'(state), 64'd3);
      chk("full_ovf", 64'(overflow), 64'd0);
      for (int i = 0; i < 16; i++) begin
         chk("drain_pc", 64'(rd_data[15:0]), 64'(16'h1000 + 16'(2 * i)));
         chk("drain_ir", 64'(rd_data[31:16]), 64'(i));
         pop();
      end
      chk("drain_count", 64'(count), 64'd0);

      // Full plus one extra back-to-back decode, no read -> overflow
      do_arm(16'h2000);
      for (int i = 0; i < 17; i++) dec(16'h2000 + 16'(2 * i), 16'h0);
      chk("ovf_set", 64'(overflow), 64'd1);
      chk("ovf_count", 64'(count), 64'd16);
      chk("ovf_state", 64'(state), 64'd3);
      chk("ovf_head", 64'(rd_data[15:0]), 64'h2000);

      // Same case with a pop on the extra decode -> accepted
      do_arm(16'h2000);
      chk("arm_clr_ovf", 64'(overflow), 64'd0);
      for (int i = 0; i < 16; i++) dec(16'h2000 + 16'(2 * i), 16'h0);
      rd_ready = 1'b1;
      dec(16'h2020, 16'h0);
      rd_ready = 1'b0;
      chk("pp_count", 64'(count), 64'd16);
      chk("pp_ovf", 64'(overflow), 64'd0);
      chk("pp_head", 64'(rd_data[15:0]), 64'h2002);
      for (int i = 0; i < 15; i++) pop();
      chk("pp_tail", 64'(rd_data[15:0]), 64'h2020);
      pop();

      // Reset mid-capture
      do_arm(16'h3000);
      for (int i = 0; i < 5; i++) dec(16'h3000 + 16'(2 * i), 16'h0);
      chk("pre_rst_count", 64'(count), 64'd5);
      puc_n = 1'b0;
      tick();
      puc_n = 1'b1;
      chk("mid_rst_state", 64'(state), 64'd0);
      chk("mid_rst_count", 64'(count), 64'd0);
      chk("mid_rst_valid", 64'(rd_valid), 64'd0);

      // arm together with a matching decode: no entry
      arm = 1'b1; trig_pc = 16'h3000; decode = 1'b1; pc = 16'h3000;
      tick();
      arm = 1'b0; decode = 1'b0;
      chk("arm_dec_state", 64'(state), 64'd1);
      chk("arm_dec_count", 64'(count), 64'd0);

      // stop in ARMED, then re-arm from DONE
      stop = 1'b1;
      tick();
      stop = 1'b0;
      chk("stop_armed", 64'(state), 64'd3);
      dec(16'h3000, 16'h0);
      chk("done_ignore", 64'(count), 64'd0);
      do_arm(16'h3000);
      chk("rearm", 64'(state), 64'd1);

`ifdef MSP_TRACE_CYCLE_EN
      do_arm(16'h4000);
      dec(16'h4000, 16'h0);
      for (int i = 0; i < 6; i++) tick();
      dec(16'h4002, 16'h0);
      chk("stamp_trig", 64'(rd_data[48:33]), 64'd0);
      pop();
      chk("stamp_7", 64'(rd_data[48:33]), 64'd7);
      pop();
      for (int i = 0; i < 70000; i++) tick();
      dec(16'h4004, 16'h0);
      chk("stamp_sat", 64'(rd_data[48:33]), 64'hFFFF);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
